// File: rtl/id_ex_skid_pkg.sv
// Shared widths, NOP constants and slot-occupancy state encodings for the
// decode-to-execute hand-off.
package id_ex_skid_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0]  ZERO          = '0;
  localparam logic [RADDR_WIDTH-1:0] ZERO_REG      = '0;
  localparam logic                   WRITE_ENABLE  = 1'b1;
  localparam logic                   WRITE_DISABLE = 1'b0;
  localparam logic [DATA_WIDTH-1:0]  INST_NOP      = 32'h0000_0013;

  // Encoding is {skid valid, main valid}; 2'b10 can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/id_ex_skid_pipe_slot.sv
// One payload slot of the hand-off: a load-enabled bundle register that
// resets to the NOP bundle.
module pipe_slot #(
  parameter int              DW       = 32,
  parameter int              AW       = 5,
  parameter logic [DW-1:0]   NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] inst_i,
  input  logic [DW-1:0] op1_i,
  input  logic [DW-1:0] op2_i,
  input  logic          wen_i,
  input  logic [AW-1:0] waddr_i,
  output logic [DW-1:0] inst_o,
  output logic [DW-1:0] op1_o,
  output logic [DW-1:0] op2_o,
  output logic          wen_o,
  output logic [AW-1:0] waddr_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o  <= NOP_INST;
      op1_o   <= '0;
      op2_o   <= '0;
      wen_o   <= 1'b0;
      waddr_o <= '0;
    end else if (load_i) begin
      inst_o  <= inst_i;
      op1_o   <= op1_i;
      op2_o   <= op2_i;
      wen_o   <= wen_i;
      waddr_o <= waddr_i;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline register with a one-entry skid buffer so decode
// sees a registered ready; flush squashes everything held or arriving.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int            DW       = DATA_WIDTH,
  parameter int            AW       = RADDR_WIDTH,
  parameter logic [DW-1:0] NOP_INST = INST_NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_in,
  input  logic          id_valid_in,
  output logic          id_ready_out,
  input  logic [DW-1:0] inst_in,
  input  logic [DW-1:0] op1_in,
  input  logic [DW-1:0] op2_in,
  input  logic          reg_wenable_in,
  input  logic [AW-1:0] reg_waddr_in,
  output logic          ex_valid_out,
  input  logic          ex_ready_in,
  output logic [DW-1:0] inst_out,
  output logic [DW-1:0] op1_out,
  output logic [DW-1:0] op2_out,
  output logic          reg_wenable_out,
  output logic [AW-1:0] reg_waddr_out
);

  state_e state_q, state_d;

  logic          mainValid, skidValid, accept, pop;
  logic          loadMain, loadSkid, mainFromSkid;

  logic [DW-1:0] mainInst_d, mainOp1_d, mainOp2_d;
  logic          mainWen_d;
  logic [AW-1:0] mainWaddr_d;

  logic [DW-1:0] mainInst_q, mainOp1_q, mainOp2_q;
  logic          mainWen_q;
  logic [AW-1:0] mainWaddr_q;

  logic [DW-1:0] skidInst_q, skidOp1_q, skidOp2_q;
  logic          skidWen_q;
  logic [AW-1:0] skidWaddr_q;

  // Ready depends only on registered state, never on ex_ready_in.
  assign mainValid = state_q[0];
  assign skidValid = state_q[1];
  assign accept    = id_valid_in & ~skidValid & ~flush_in;
  assign pop       = mainValid & ex_ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    if (flush_in) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_ONE;
            loadMain = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            loadMain = 1'b1;
          end else if (accept) begin
            state_d  = ST_FULL;
            loadSkid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d      = ST_ONE;
            loadMain     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    id_ready_out = ~skidValid;
    ex_valid_out = mainValid;
    if (mainValid) begin
      inst_out        = mainInst_q;
      op1_out         = mainOp1_q;
      op2_out         = mainOp2_q;
      reg_wenable_out = mainWen_q;
      reg_waddr_out   = mainWaddr_q;
    end else begin
      inst_out        = NOP_INST;
      op1_out         = '0;
      op2_out         = '0;
      reg_wenable_out = WRITE_DISABLE;
      reg_waddr_out   = '0;
    end
  end

  assign mainInst_d  = mainFromSkid ? skidInst_q  : inst_in;
  assign mainOp1_d   = mainFromSkid ? skidOp1_q   : op1_in;
  assign mainOp2_d   = mainFromSkid ? skidOp2_q   : op2_in;
  assign mainWen_d   = mainFromSkid ? skidWen_q   : reg_wenable_in;
  assign mainWaddr_d = mainFromSkid ? skidWaddr_q : reg_waddr_in;

  pipe_slot #(.DW(DW), .AW(AW), .NOP_INST(NOP_INST)) uMainSlot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (loadMain),
    .inst_i  (mainInst_d),
    .op1_i   (mainOp1_d),
    .op2_i   (mainOp2_d),
    .wen_i   (mainWen_d),
    .waddr_i (mainWaddr_d),
    .inst_o  (mainInst_q),
    .op1_o   (mainOp1_q),
    .op2_o   (mainOp2_q),
    .wen_o   (mainWen_q),
    .waddr_o (mainWaddr_q)
  );

  pipe_slot #(.DW(DW), .AW(AW), .NOP_INST(NOP_INST)) uSkidSlot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (loadSkid),
    .inst_i  (inst_in),
    .op1_i   (op1_in),
    .op2_i   (op2_in),
    .wen_i   (reg_wenable_in),
    .waddr_i (reg_waddr_in),
    .inst_o  (skidInst_q),
    .op1_o   (skidOp1_q),
    .op2_o   (skidOp2_q),
    .wen_o   (skidWen_q),
    .waddr_o (skidWaddr_q)
  );

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid: directed scenarios followed by a long
// random valid/ready/flush run against a FIFO model of the held bundles.
module tb_id_ex_skid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  waddr;
  } bundle_t;

  logic        clk, rst, flush_in, id_valid_in, id_ready_out;
  logic [31:0] inst_in, op1_in, op2_in;
  logic        reg_wenable_in;
  logic [4:0]  reg_waddr_in;
  logic        ex_valid_out, ex_ready_in;
  logic [31:0] inst_out, op1_out, op2_out;
  logic        reg_wenable_out;
  logic [4:0]  reg_waddr_out;

  bundle_t sb[$];
  int      compared   = 0;
  int      mismatched = 0;

  id_ex_skid dut (
    .clk             (clk),
    .rst             (rst),
    .flush_in        (flush_in),
    .id_valid_in     (id_valid_in),
    .id_ready_out    (id_ready_out),
    .inst_in         (inst_in),
    .op1_in          (op1_in),
    .op2_in          (op2_in),
    .reg_wenable_in  (reg_wenable_in),
    .reg_waddr_in    (reg_waddr_in),
    .ex_valid_out    (ex_valid_out),
    .ex_ready_in     (ex_ready_in),
    .inst_out        (inst_out),
    .op1_out         (op1_out),
    .op2_out         (op2_out),
    .reg_wenable_out (reg_wenable_out),
    .reg_waddr_out   (reg_waddr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Everything the outputs must show while no valid entry is presented.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_inst"},  128'(inst_out),        128'(32'h0000_0013));
    checkOutput({tag, "_op1"},   128'(op1_out),         128'(0));
    checkOutput({tag, "_op2"},   128'(op2_out),         128'(0));
    checkOutput({tag, "_wen"},   128'(reg_wenable_out), 128'(0));
    checkOutput({tag, "_waddr"}, 128'(reg_waddr_out),   128'(0));
  endtask

  function automatic bundle_t makeBundle(input int n);
    bundle_t b;
    b.inst  = 32'h1000_0000 | n;
    b.op1   = n * 3;
    b.op2   = ~n;
    b.we    = n[0];
    b.waddr = n[4:0];
    return b;
  endfunction

  // One clock cycle: drive at +1 after the edge, check and update the model
  // at the falling edge, then advance past the next rising edge.
  task automatic applyStimulus(input logic v, input bundle_t b, input logic exr, input logic fl);
    int held;
    id_valid_in    = v;
    inst_in        = b.inst;
    op1_in         = b.op1;
    op2_in         = b.op2;
    reg_wenable_in = b.we;
    reg_waddr_in   = b.waddr;
    ex_ready_in    = exr;
    flush_in       = fl;
    @(negedge clk);
    held = sb.size();
    checkOutput("ready",    128'(id_ready_out), 128'(held < 2));
    checkOutput("ex_valid", 128'(ex_valid_out), 128'(held > 0));
    if (held == 0) begin
      checkIdle("idle");
    end else begin
      checkOutput("bundle",
                  128'({inst_out, op1_out, op2_out, reg_wenable_out, reg_waddr_out}),
                  128'(sb[0]));
      if (exr) void'(sb.pop_front());
    end
    if (fl) sb.delete();
    else if (v && held < 2) sb.push_back(b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bundle_t addi, a, bb, c, d, r;
    rst            = 1'b0;
    flush_in       = 1'b0;
    id_valid_in    = 1'b0;
    ex_ready_in    = 1'b0;
    inst_in        = '0;
    op1_in         = '0;
    op2_in         = '0;
    reg_wenable_in = 1'b0;
    reg_waddr_in   = '0;

    #2;
    checkOutput("rst_ready", 128'(id_ready_out), 128'(1));
    checkOutput("rst_valid", 128'(ex_valid_out), 128'(0));
    checkIdle("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    addi = '{inst: 32'hFFF0_8293, op1: 32'd7, op2: 32'hFFFF_FFFF, we: 1'b1, waddr: 5'd5};
    applyStimulus(1'b1, addi, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, makeBundle(i + 1), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    a  = makeBundle(16'hA0);
    bb = makeBundle(16'hB1);
    c  = makeBundle(16'hC2);
    applyStimulus(1'b1, a,  1'b0, 1'b0);
    applyStimulus(1'b1, bb, 1'b0, 1'b0);
    applyStimulus(1'b1, c,  1'b0, 1'b0);
    applyStimulus(1'b1, c,  1'b0, 1'b0);
    applyStimulus(1'b1, c,  1'b1, 1'b0);
    applyStimulus(1'b1, c,  1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    d = makeBundle(16'hD3);
    applyStimulus(1'b1, a,  1'b0, 1'b0);
    applyStimulus(1'b1, bb, 1'b0, 1'b0);
    applyStimulus(1'b1, d,  1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    applyStimulus(1'b1, a, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 128'(ex_valid_out), 128'(0));
    checkOutput("arst_ready", 128'(id_ready_out), 128'(1));
    checkIdle("arst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, bb, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      r.inst  = $urandom;
      r.op1   = $urandom;
      r.op2   = $urandom;
      r.we    = 1'($urandom);
      r.waddr = 5'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
